hilo_unit: RTL and testbench
============================

# hilo_unit

Issue/retire front end for the serial multiplier/divider (`multdiv`) in the MIPS execute stage. It decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the pipeline and drives the `multdiv` start/operand interface. It collects `prodh`/`prodl` into the architectural HI/LO registers and stalls the pipeline while a HI/LO access would read stale data.

## Interface
- No parameters; all data paths are 32 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- op_valid  in  1  a HI/LO-class instruction is present in the stage.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
- rs_val  in  32  rs operand (dividend/multiplicand; MTHI/MTLO source).
- rt_val  in  32  rt operand (divisor/multiplier).
- stall  out  1  combinational; holds the pipeline; the op is accepted on an edge where op_valid=1 and stall=0.
- rd_val  out  32  combinational; HI for MFHI, LO for MFLO, 0 otherwise.
- hi, lo  out  32  architectural HI/LO registers.
- div0  out  1  registered one-cycle pulse; a retiring DIV/DIVU had divisor 0.
- md_start  out  1  registered one-cycle start pulse to `multdiv`.
- md_multdivb  out  1  1 = multiply, 0 = divide; held until retire.
- md_signedop  out  1  1 = signed (MULT/DIV); held until retire.
- md_x, md_y  out  32 each  operands latched from rs_val, rt_val; held until retire.
- md_prodh, md_prodl  in  32 each  `multdiv` result; divide gives remainder in prodh, quotient in prodl.
- md_run  in  1  `multdiv` busy.
- md_dividebyzero  in  1  `multdiv` divide-by-zero indication.

## Operation
- FSM states are IDLE, ISSUE and BUSY.
- **IDLE.** When a MULT/MULTU/DIV/DIVU is accepted:
  - md_x <= rs_val, md_y <= rt_val, md_multdivb <= ~op[1], md_signedop <= ~op[0].
  - md_start <= 1; go to ISSUE.
- **ISSUE.** md_start <= 0; go to BUSY unconditionally. `multdiv` samples start at the end of ISSUE and raises md_run during the first BUSY cycle.
- **BUSY.** While md_run=1, hold. On the first edge with md_run=0 (retire):
  - hi <= md_prodh, lo <= md_prodl.
  - div0 <= md_dividebyzero & ~md_multdivb.
  - Go to IDLE.
- div0 is 0 on every other edge.
- **MTHI/MTLO.** Accepted only in IDLE; hi <= rs_val (resp. lo <= rs_val) at the accepting edge.
- **MFHI/MFLO.** Accepted only in IDLE; rd_val shows the current hi/lo in the same cycle.
- **Stall rule.** stall = op_valid & (state != IDLE). Every HI/LO-class op stalls while a multiply/divide is outstanding, so no new op can issue and no read can see stale HI/LO.
- **Non-HI/LO traffic.** op_valid=0 never stalls; independent instructions flow while `multdiv` runs.
- **Reset.** On reset low, regardless of state:
  - state=IDLE; hi=lo=0; md_start=0; md_x=md_y=0; md_multdivb=0; md_signedop=0; div0=0.
  - stall and rd_val follow combinationally: stall=0; rd_val=0 for MFHI/MFLO.
- **Reset mid-operation.** An in-flight op is abandoned and its result is never written. `multdiv` shares the same reset source (inverted at integration).

## Timing
- **MULT/DIV latency.** Accept edge T0, ISSUE during T0..T1, BUSY from T1. HI/LO update at the first BUSY edge seeing md_run=0, which is `multdiv` latency + 2 edges after T0.
- **MFHI/MFLO after MULT/DIV.** Issued back-to-back after a MULT/DIV, it sees stall=1 from T0+1 through the retire edge. stall falls in the cycle after retire, and rd_val then equals the new HI/LO.
- **MTHI/MTLO then MFHI/MFLO.** Back-to-back pair takes zero stall cycles; the read returns the just-written value.
- **Start pulse.** md_start is high for exactly one cycle per accepted multiply/divide. Operand outputs are stable from ISSUE through retire.
- **Same-cycle ops.** Simultaneous events cannot occur: at most one op is presented per cycle, and only IDLE accepts.

## Test plan
- **Signed multiply.** MULT rs=FFFFFFFF, rt=00000002 → one md_start pulse; after retire hi=FFFFFFFF, lo=FFFFFFFE; div0=0.
- **Unsigned divide.** DIVU rs=00000007, rt=00000002 → md_multdivb=0, md_signedop=0; after retire lo=00000003, hi=00000001.
- **Back-to-back read.** MULTU rs=80000000, rt=00000002, then MFLO immediately → stall=1 each cycle until retire, then stall=0 with rd_val=00000000; MFHI next cycle gives rd_val=00000001.
- **Divide by zero.** DIV rs=00000005, rt=00000000 → div0 high for exactly one cycle at the retire edge; a following MTHI/MTLO is stalled until then.
- **Move to/from HI.** MTHI rs=12345678 in IDLE, then MFHI → no stall; rd_val=12345678; lo unchanged.
- **Reset mid-operation.** Drive reset low during BUSY of MULT 7FFFFFFF×7FFFFFFF → hi=lo=0, stall=0, md_start=0 immediately. After reset release, MULTU 00000003×00000004 gives lo=0000000C, hi=0.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO issue/retire front end for the serial multdiv unit: decodes HI/LO-class ops,
// launches multiply/divide, collects results into HI/LO and stalls stale accesses.
module hilo_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic [31:0] rd_val,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0,
  output logic        md_start,
  output logic        md_multdivb,
  output logic        md_signedop,
  output logic [31:0] md_x,
  output logic [31:0] md_y,
  input  logic [31:0] md_prodh,
  input  logic [31:0] md_prodl,
  input  logic        md_run,
  input  logic        md_dividebyzero
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  localparam logic [2:0] OP_MFHI = 3'b100;
  localparam logic [2:0] OP_MFLO = 3'b101;
  localparam logic [2:0] OP_MTHI = 3'b110;
  localparam logic [2:0] OP_MTLO = 3'b111;

  state_t      r_state, w_next;
  logic [31:0] r_hi, r_lo, r_x, r_y;
  logic        r_start, r_div0, r_multdivb, r_signedop;
  logic        w_accept, w_md_go, w_retire;

  assign w_accept = op_valid & (r_state == S_IDLE);
  assign w_md_go  = w_accept & ~op[2];
  assign w_retire = (r_state == S_BUSY) & ~md_run;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_md_go) w_next = S_ISSUE;
      S_ISSUE: w_next = S_BUSY;
      S_BUSY:  if (!md_run) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_start    <= 1'b0;
      r_div0     <= 1'b0;
      r_multdivb <= 1'b0;
      r_signedop <= 1'b0;
    end else begin
      r_start <= w_md_go;
      r_div0  <= w_retire & md_dividebyzero & ~r_multdivb;
      if (w_md_go) begin
        r_x        <= rs_val;
        r_y        <= rt_val;
        r_multdivb <= ~op[1];
        r_signedop <= ~op[0];
      end
      // Retire only happens in BUSY and moves only in IDLE, so these never collide.
      if (w_retire) begin
        r_hi <= md_prodh;
        r_lo <= md_prodl;
      end else if (w_accept && op == OP_MTHI) begin
        r_hi <= rs_val;
      end else if (w_accept && op == OP_MTLO) begin
        r_lo <= rs_val;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (op_valid && op == OP_MFHI) rd_val = r_hi;
    if (op_valid && op == OP_MFLO) rd_val = r_lo;
  end

  assign stall       = op_valid & (r_state != S_IDLE);
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div0        = r_div0;
  assign md_start    = r_start;
  assign md_multdivb = r_multdivb;
  assign md_signedop = r_signedop;
  assign md_x        = r_x;
  assign md_y        = r_y;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: a behavioural multdiv stand-in with configurable latency,
// directed and random HI/LO sequences checked against arithmetic expectations.
module tb_hilo_unit;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MFHI = 3'd4, MFLO = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        stall, div0, md_start, md_multdivb, md_signedop;
  logic [31:0] rd_val, hi, lo, md_x, md_y;
  logic [31:0] md_prodh, md_prodl;
  logic        md_run, md_dividebyzero;

  int          n_checks = 0;
  int          n_pass = 0;
  int          lat_cfg = 1;
  int          md_cnt;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  hilo_unit dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .rd_val(rd_val),
    .hi(hi), .lo(lo), .div0(div0), .md_start(md_start),
    .md_multdivb(md_multdivb), .md_signedop(md_signedop),
    .md_x(md_x), .md_y(md_y), .md_prodh(md_prodh), .md_prodl(md_prodl),
    .md_run(md_run), .md_dividebyzero(md_dividebyzero)
  );

  always #5 clk = ~clk;

  // multdiv stand-in: computes from the operand bus it is handed
  task automatic stub_calc(input logic mul, input logic sgn, input logic [31:0] x, y,
                           output logic [31:0] h, l, output logic d);
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0] ux, uy, r;
    sx = $signed({{32{x[31]}}, x});
    sy = $signed({{32{y[31]}}, y});
    ux = {32'd0, x};
    uy = {32'd0, y};
    d  = (y == 32'd0);
    if (mul) begin
      r = sgn ? 64'(sx * sy) : ux * uy;
      h = r[63:32];
      l = r[31:0];
    end else if (y == 32'd0) begin
      h = x;
      l = '1;
    end else if (sgn) begin
      sq = sx / sy;
      sr = sx % sy;
      h = sr[31:0];
      l = sq[31:0];
    end else begin
      r = ux % uy;
      h = r[31:0];
      r = ux / uy;
      l = r[31:0];
    end
  endtask

  always @(posedge clk or negedge reset) begin
    logic [31:0] th, tl;
    logic td;
    if (!reset) begin
      md_run <= 1'b0;
      md_cnt <= 0;
      md_prodh <= '0;
      md_prodl <= '0;
      md_dividebyzero <= 1'b0;
    end else if (md_start) begin
      md_run <= 1'b1;
      md_cnt <= lat_cfg;
    end else if (md_run) begin
      if (md_cnt <= 1) begin
        stub_calc(md_multdivb, md_signedop, md_x, md_y, th, tl, td);
        md_run <= 1'b0;
        md_prodh <= th;
        md_prodl <= tl;
        md_dividebyzero <= td;
      end else begin
        md_cnt <= md_cnt - 1;
      end
    end
  end

  // Architectural expectation straight from the instruction semantics
  task automatic expect_op(input logic [2:0] o, input logic [31:0] a, b,
                           output logic [31:0] h, l, output logic d);
    logic signed [63:0] p, q, r;
    logic [63:0] u;
    d = 1'b0;
    h = '0;
    l = '0;
    case (o)
      MULT:  begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); h = p[63:32]; l = p[31:0]; end
      MULTU: begin u = {32'd0, a} * {32'd0, b}; h = u[63:32]; l = u[31:0]; end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; d = 1'b1;
        end else if (o == DIV) begin
          q = $signed({{32{a[31]}}, a}) / $signed({{32{b[31]}}, b});
          r = $signed({{32{a[31]}}, a}) % $signed({{32{b[31]}}, b});
          h = r[31:0]; l = q[31:0];
        end else begin
          h = a % b; l = a / b;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic md_seq(input logic [2:0] mop, input logic [31:0] a, b, input int lat,
                        input logic [2:0] fop, input logic [31:0] frs);
    logic [31:0] eh, el;
    logic ed;
    int n;
    expect_op(mop, a, b, eh, el, ed);
    @(negedge clk);
    op_valid = 1'b1; op = mop; rs_val = a; rt_val = b; lat_cfg = lat;
    #1 chk("md_accept_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("md_start", 32'(md_start), 32'd1);
    chk("md_multdivb", 32'(md_multdivb), 32'(mop == MULT || mop == MULTU));
    chk("md_signedop", 32'(md_signedop), 32'(mop == MULT || mop == DIV));
    op = fop; rs_val = frs; rt_val = $urandom;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 64) begin
      n++;
      if (n == 2) begin
        chk("md_start_pulse", 32'(md_start), 32'd0);
        chk("md_x_held", md_x, a);
        chk("md_y_held", md_y, b);
      end
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", 32'(n), 32'(lat + 2));
    chk("hi_retire", hi, eh);
    chk("lo_retire", lo, el);
    chk("div0_retire", 32'(div0), 32'(ed));
    if (fop == MFHI) chk("rd_mfhi_after", rd_val, eh);
    if (fop == MFLO) chk("rd_mflo_after", rd_val, el);
    if (fop == MTHI) eh = frs;
    if (fop == MTLO) el = frs;
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    chk("div0_pulse_end", 32'(div0), 32'd0);
    if (fop == MTHI || fop == MTLO) begin
      chk("hi_after_mt", hi, eh);
      chk("lo_after_mt", lo, el);
    end
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk);
    op_valid = 1'b1; op = o; rs_val = v;
    #1 chk("mt_stall", 32'(stall), 32'd0);
    if (o == MTHI) exp_hi = v;
    else exp_lo = v;
  endtask

  task automatic mf(input logic [2:0] o);
    @(negedge clk);
    op_valid = 1'b1; op = o;
    #1 chk("mf_stall", 32'(stall), 32'd0);
    chk("mf_rd_val", rd_val, (o == MFHI) ? exp_hi : exp_lo);
    chk("mf_hi_reg", hi, exp_hi);
    chk("mf_lo_reg", lo, exp_lo);
  endtask

  initial begin
    logic [2:0] rop, rfop;
    logic [31:0] ra, rb;
    #2 reset = 1'b0;
    op_valid = 1'b1; op = MFLO;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rd_val", rd_val, 32'd0);
    chk("rst_md_start", 32'(md_start), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    chk("rst_md_x", md_x, 32'd0);
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    md_seq(MULT, 32'hFFFF_FFFF, 32'h0000_0002, 3, MFLO, 32'd0);
    md_seq(DIVU, 32'h0000_0007, 32'h0000_0002, 5, MFHI, 32'd0);
    md_seq(MULTU, 32'h8000_0000, 32'h0000_0002, 4, MFLO, 32'd0);
    mf(MFHI);
    md_seq(DIV, 32'h0000_0005, 32'h0000_0000, 2, MTHI, 32'hAAAA_5555);
    mt(MTHI, 32'h1234_5678);
    mf(MFHI);
    mt(MTLO, 32'h0BAD_F00D);
    mf(MFLO);

    for (int i = 0; i < 24; i++) begin
      rop  = 3'($urandom_range(0, 3));
      rfop = 3'(4 + $urandom_range(0, 3));
      ra   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rb   = ($urandom_range(0, 5) == 0) ? 32'd0 :
             ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      md_seq(rop, ra, rb, $urandom_range(1, 6), rfop, $urandom);
      if ($urandom_range(0, 1) == 1) mf(($urandom_range(0, 1) == 1) ? MFHI : MFLO);
    end

    mt(MTHI, 32'hDEAD_BEEF);
    mt(MTLO, 32'hCAFE_F00D);
    @(negedge clk);
    op_valid = 1'b1; op = MULT; rs_val = 32'h7FFF_FFFF; rt_val = 32'h7FFF_FFFF; lat_cfg = 8;
    @(negedge clk);
    op = MFHI;
    repeat (3) @(negedge clk);
    #1 chk("busy_stall", 32'(stall), 32'd1);
    op_valid = 1'b0;
    #1 chk("nonhilo_no_stall", 32'(stall), 32'd0);
    op_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_md_start", 32'(md_start), 32'd0);
    chk("midrst_rd_val", rd_val, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    op_valid = 1'b0;
    md_seq(MULTU, 32'h0000_0003, 32'h0000_0004, 2, MFLO, 32'd0);
    mf(MFHI);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
